// File: rtl/cpu_run_ctrl.sv
// Run controller: arbitrates the single-port blram between a host loader and SimpleCPU,
// and tracks run length/outcome. Define RUN_ABORT_EN to add the `abort` input.
module cpu_run_ctrl #(
    parameter int unsigned SIZE       = 10,
    parameter int unsigned HALT_ADDR  = 1023,
    parameter logic [31:0] MAX_CYCLES = 32'd65535
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
`ifdef RUN_ABORT_EN
    input  logic            abort,
`endif
    output logic            busy,
    output logic            done,
    output logic            timeout,
    output logic [31:0]     halt_code,
    output logic [31:0]     cycles,
    input  logic            host_req,
    input  logic            host_we,
    input  logic [SIZE-1:0] host_addr,
    input  logic [31:0]     host_wdata,
    output logic            host_gnt,
    output logic            host_rvalid,
    output logic [31:0]     host_rdata,
    output logic            cpu_rst,
    input  logic            cpu_wrEn,
    input  logic [SIZE-1:0] cpu_addr,
    input  logic [31:0]     cpu_wdata,
    output logic [31:0]     cpu_rdata,
    output logic            ram_we,
    output logic [SIZE-1:0] ram_addr,
    output logic [31:0]     ram_wdata,
    input  logic [31:0]     ram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [SIZE-1:0] HALT_A = SIZE'(HALT_ADDR);

    state_t      state_q, state_d;
    logic        cpu_rst_q, cpu_rst_d;
    logic        timeout_q, timeout_d;
    logic [31:0] halt_code_q, halt_code_d;
    logic [31:0] cycles_q, cycles_d;
    logic        host_rvalid_q, host_rvalid_d;
    logic        halt_s;
    logic        abort_s;
    logic        budget_hit_s;

`ifdef RUN_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    assign halt_s       = cpu_wrEn && (cpu_addr == HALT_A) && (cpu_wdata != 32'd0);
    assign budget_hit_s = (MAX_CYCLES != 32'd0) && (cycles_q == (MAX_CYCLES - 32'd1));

    // State register and result flops; cpu_rst comes straight from a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cpu_rst_q     <= 1'b1;
            timeout_q     <= 1'b0;
            halt_code_q   <= 32'd0;
            cycles_q      <= 32'd0;
            host_rvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cpu_rst_q     <= cpu_rst_d;
            timeout_q     <= timeout_d;
            halt_code_q   <= halt_code_d;
            cycles_q      <= cycles_d;
            host_rvalid_q <= host_rvalid_d;
        end
    end

    // Next-state logic: run start, end-of-run priority (halt > abort > budget).
    always_comb begin
        state_d       = state_q;
        cpu_rst_d     = cpu_rst_q;
        timeout_d     = timeout_q;
        halt_code_d   = halt_code_q;
        cycles_d      = cycles_q;
        host_rvalid_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                cycles_d = cycles_q + 32'd1;
                if (halt_s) begin
                    state_d     = ST_DONE;
                    cpu_rst_d   = 1'b1;
                    timeout_d   = 1'b0;
                    halt_code_d = cpu_wdata;
                end else if (abort_s) begin
                    state_d     = ST_DONE;
                    cpu_rst_d   = 1'b1;
                    timeout_d   = 1'b0;
                    halt_code_d = 32'hFFFF_FFFF;
                end else if (budget_hit_s) begin
                    state_d   = ST_DONE;
                    cpu_rst_d = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_IDLE, ST_DONE: begin
                cpu_rst_d = 1'b1;
                if (start) begin
                    state_d     = ST_RUN;
                    cpu_rst_d   = 1'b0;
                    cycles_d    = 32'd0;
                    timeout_d   = 1'b0;
                    halt_code_d = 32'd0;
                end else begin
                    // A read granted now returns its data next cycle; suppressed when entering RUN.
                    host_rvalid_d = host_req && !host_we;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cpu_rst_d = 1'b1;
            end
        endcase
    end

    // RAM port steering: CPU passthrough in RUN, host otherwise (zeros when host is quiet).
    always_comb begin
        host_gnt  = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = {SIZE{1'b0}};
        ram_wdata = 32'd0;
        cpu_rdata = 32'd0;
        if (state_q == ST_RUN) begin
            ram_we    = cpu_wrEn;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
            cpu_rdata = ram_rdata;
        end else begin
            host_gnt = host_req;
            if (host_req) begin
                ram_we    = host_we;
                ram_addr  = host_addr;
                ram_wdata = host_wdata;
            end else begin
                ram_we    = 1'b0;
                ram_addr  = {SIZE{1'b0}};
                ram_wdata = 32'd0;
            end
        end
    end

    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign timeout     = timeout_q;
    assign halt_code   = halt_code_q;
    assign cycles      = cycles_q;
    assign cpu_rst     = cpu_rst_q;
    assign host_rvalid = host_rvalid_q;
    assign host_rdata  = host_rvalid_q ? ram_rdata : 32'd0;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: blram model plus a scripted CPU bus, checked
// against an outcome model (run length, end reason, expected memory image).
module tb_cpu_run_ctrl;

    localparam int MAXC = 100;

    logic        clk, rst, start;
`ifdef RUN_ABORT_EN
    logic        abort;
`endif
    logic        busy, done, timeout;
    logic [31:0] halt_code, cycles;
    logic        host_req, host_we, host_gnt, host_rvalid;
    logic [9:0]  host_addr;
    logic [31:0] host_wdata, host_rdata;
    logic        cpu_rst, cpu_wrEn;
    logic [9:0]  cpu_addr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;

    int checks = 0;
    int failures = 0;

    logic [31:0] ram_mem [0:1023];
    logic [31:0] exp_mem [0:1023];

    cpu_run_ctrl #(.SIZE(10), .HALT_ADDR(1023), .MAX_CYCLES(32'd100)) dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef RUN_ABORT_EN
        .abort(abort),
`endif
        .busy(busy), .done(done), .timeout(timeout), .halt_code(halt_code), .cycles(cycles),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .cpu_rst(cpu_rst), .cpu_wrEn(cpu_wrEn), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port blram, read-first, one-cycle read latency.
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic quiet_inputs();
        start = 1'b0; host_req = 1'b0; host_we = 1'b0; host_addr = 10'd0; host_wdata = 32'd0;
        cpu_wrEn = 1'b0; cpu_addr = 10'd0; cpu_wdata = 32'd0;
`ifdef RUN_ABORT_EN
        abort = 1'b0;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b0;
        quiet_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (cpu_rst !== 1'b1) begin failures++; $display("FAIL reset_cpu_rst got=%0b exp=1", cpu_rst); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_busy_done got=%0b%0b exp=00", busy, done); end
        checks++; if (cycles !== 32'd0 || halt_code !== 32'd0 || timeout !== 1'b0) begin failures++; $display("FAIL reset_results cycles=%0d code=%h to=%0b exp=0", cycles, halt_code, timeout); end
        checks++; if (host_rvalid !== 1'b0 || host_rdata !== 32'd0) begin failures++; $display("FAIL reset_rvalid got=%0b/%h exp=0", host_rvalid, host_rdata); end
        @(posedge clk); #1;
        rst = 1'b1; host_req = 1'b1; host_we = 1'b1; host_addr = 10'd40; host_wdata = 32'h5A5A;
        exp_mem[40] = 32'h5A5A;
        @(negedge clk);
        checks++; if (host_gnt !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 10'd40) begin failures++; $display("FAIL reset_gnt_follow got=%0b/%0b/%0d exp=1/1/40", host_gnt, ram_we, ram_addr); end
        @(posedge clk); #1;
        host_req = 1'b0;
        @(negedge clk);
        checks++; if (host_gnt !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 10'd0 || ram_wdata !== 32'd0) begin failures++; $display("FAIL reset_quiet_ram got=%0b/%0b/%0d/%h exp=0", host_gnt, ram_we, ram_addr, ram_wdata); end
    endtask

    task automatic test_host_load();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            host_req = 1'b1; host_we = 1'b1; host_addr = 10'(i); host_wdata = 32'(i + 1) * 32'h11;
            exp_mem[i] = host_wdata;
            @(negedge clk);
            checks++; if (host_gnt !== 1'b1 || ram_we !== 1'b1 || ram_wdata !== 32'(i + 1) * 32'h11) begin failures++; $display("FAIL load_write%0d got=%0b/%0b/%h", i, host_gnt, ram_we, ram_wdata); end
        end
        @(posedge clk); #1;
        host_we = 1'b0; host_addr = 10'd2;
        @(negedge clk);
        checks++; if (host_rvalid !== 1'b0 || ram_we !== 1'b0) begin failures++; $display("FAIL load_read_issue got=%0b/%0b exp=0/0", host_rvalid, ram_we); end
        @(posedge clk); #1;
        host_addr = 10'd0;
        @(negedge clk);
        checks++; if (host_rvalid !== 1'b1 || host_rdata !== 32'h33) begin failures++; $display("FAIL load_read2 got=%0b/%h exp=1/33", host_rvalid, host_rdata); end
        @(posedge clk); #1;
        host_req = 1'b0;
        @(negedge clk);
        checks++; if (host_rvalid !== 1'b1 || host_rdata !== 32'h11) begin failures++; $display("FAIL load_read0 got=%0b/%h exp=1/11", host_rvalid, host_rdata); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (host_rvalid !== 1'b0 || host_rdata !== 32'd0) begin failures++; $display("FAIL load_rvalid_drop got=%0b/%h exp=0/0", host_rvalid, host_rdata); end
        // Fill the rest of the working area (3..31) back to back with random data.
        for (int i = 3; i < 32; i++) begin
            @(posedge clk); #1;
            host_req = 1'b1; host_we = 1'b1; host_addr = 10'(i); host_wdata = $urandom;
            exp_mem[i] = host_wdata;
        end
        @(posedge clk); #1;
        host_req = 1'b0; host_we = 1'b0;
    endtask

    task automatic test_halt_run();
        logic [31:0] exp_rd;
        logic [9:0]  a;
        @(posedge clk); #1;
        start = 1'b1; host_req = 1'b0;
        exp_rd = exp_mem[0];
        @(negedge clk);
        checks++; if (cpu_rst !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL halt_pre_start got=%0b/%0b exp=1/0", cpu_rst, busy); end
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            host_req = 1'b1; host_we = 1'b1; host_addr = 10'd7; host_wdata = 32'hDEAD;
            a = (k == 5) ? 10'd1023 : 10'($urandom_range(0, 31));
            cpu_wrEn = (k == 5); cpu_addr = a; cpu_wdata = (k == 5) ? 32'd7 : 32'd0;
            @(negedge clk);
            checks++; if (busy !== 1'b1 || cpu_rst !== 1'b0 || cycles !== 32'(k - 1)) begin failures++; $display("FAIL halt_run%0d busy=%0b cpu_rst=%0b cycles=%0d exp=1/0/%0d", k, busy, cpu_rst, cycles, k - 1); end
            checks++; if (host_gnt !== 1'b0 || host_rvalid !== 1'b0 || ram_addr !== a || ram_we !== (k == 5) || cpu_rdata !== exp_rd) begin failures++; $display("FAIL halt_pass%0d gnt=%0b rv=%0b addr=%0d we=%0b rd=%h exp_addr=%0d exp_rd=%h", k, host_gnt, host_rvalid, ram_addr, ram_we, cpu_rdata, a, exp_rd); end
            exp_rd = exp_mem[a];
        end
        exp_mem[1023] = 32'd7;
        @(posedge clk); #1;
        cpu_wrEn = 1'b0; host_req = 1'b0;
        @(negedge clk);
        checks++; if (done !== 1'b1 || busy !== 1'b0 || cpu_rst !== 1'b1) begin failures++; $display("FAIL halt_done got=%0b/%0b/%0b exp=1/0/1", done, busy, cpu_rst); end
        checks++; if (halt_code !== 32'd7 || timeout !== 1'b0 || cycles !== 32'd5) begin failures++; $display("FAIL halt_results code=%h to=%0b cycles=%0d exp=7/0/5", halt_code, timeout, cycles); end
        @(posedge clk); #1;
        host_req = 1'b1; host_we = 1'b0; host_addr = 10'd1023;
        @(posedge clk); #1;
        host_req = 1'b0;
        @(negedge clk);
        checks++; if (host_rvalid !== 1'b1 || host_rdata !== 32'd7) begin failures++; $display("FAIL halt_mailbox got=%0b/%h exp=1/7", host_rvalid, host_rdata); end
    endtask

    task automatic test_timeout();
        @(posedge clk); #1;
        start = 1'b1;
        for (int k = 1; k <= MAXC; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            cpu_wrEn = (k == 50); cpu_addr = (k == 50) ? 10'd1023 : 10'($urandom_range(0, 31)); cpu_wdata = 32'd0;
            @(negedge clk);
            checks++; if (busy !== 1'b1 || done !== 1'b0 || cycles !== 32'(k - 1)) begin failures++; $display("FAIL timeout_run%0d busy=%0b done=%0b cycles=%0d exp=1/0/%0d", k, busy, done, cycles, k - 1); end
        end
        exp_mem[1023] = 32'd0;
        @(posedge clk); #1;
        cpu_wrEn = 1'b0;
        @(negedge clk);
        checks++; if (done !== 1'b1 || timeout !== 1'b1 || cycles !== 32'd100 || halt_code !== 32'd0) begin failures++; $display("FAIL timeout_end done=%0b to=%0b cycles=%0d code=%h exp=1/1/100/0", done, timeout, cycles, halt_code); end
        @(posedge clk); #1;
        host_req = 1'b1; host_we = 1'b0; host_addr = 10'd1023;
        @(posedge clk); #1;
        host_req = 1'b0;
        @(negedge clk);
        checks++; if (host_rdata !== 32'd0 || host_rvalid !== 1'b1) begin failures++; $display("FAIL timeout_zero_mailbox got=%0b/%h exp=1/0", host_rvalid, host_rdata); end
    endtask

    task automatic test_host_blocked();
        @(posedge clk); #1;
        start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            start = (k == 8);
            host_req = 1'b1; host_we = 1'b1; host_addr = 10'd5; host_wdata = $urandom;
            cpu_wrEn = (k == 20); cpu_addr = (k == 20) ? 10'd1023 : 10'd9; cpu_wdata = (k == 20) ? 32'h1234 : 32'd0;
            @(negedge clk);
            checks++; if (host_gnt !== 1'b0 || ram_addr !== cpu_addr || cycles !== 32'(k - 1) || busy !== 1'b1) begin failures++; $display("FAIL blocked%0d gnt=%0b addr=%0d cycles=%0d busy=%0b exp=0/%0d/%0d/1", k, host_gnt, ram_addr, cycles, busy, cpu_addr, k - 1); end
        end
        exp_mem[1023] = 32'h1234;
        @(posedge clk); #1;
        start = 1'b0; cpu_wrEn = 1'b0; host_we = 1'b0; host_addr = 10'd5;
        @(negedge clk);
        checks++; if (done !== 1'b1 || cycles !== 32'd20 || halt_code !== 32'h1234) begin failures++; $display("FAIL blocked_end done=%0b cycles=%0d code=%h exp=1/20/1234", done, cycles, halt_code); end
        @(posedge clk); #1;
        host_req = 1'b0;
        @(negedge clk);
        checks++; if (host_rvalid !== 1'b1 || host_rdata !== exp_mem[5]) begin failures++; $display("FAIL blocked_mem5 got=%0b/%h exp=1/%h", host_rvalid, host_rdata, exp_mem[5]); end
    endtask

    task automatic test_random_runs();
        int          halt_cyc, exp_end;
        logic        exp_to, exp_v;
        logic [31:0] code, exp_code, exp_rd, exp_d;
        int          plan [6] = '{37, 130, 100, 99, 0, 0};
        for (int r = 0; r < 6; r++) begin
            halt_cyc = (plan[r] != 0) ? plan[r] : int'($urandom_range(1, 130));
            code     = $urandom | 32'd1;
            exp_to   = (halt_cyc > MAXC);
            exp_end  = exp_to ? MAXC : halt_cyc;
            exp_code = exp_to ? 32'd0 : code;
            @(posedge clk); #1;
            start = 1'b1; host_req = 1'b0;
            exp_rd = exp_mem[0];
            for (int k = 1; k <= exp_end; k++) begin
                @(posedge clk); #1;
                start = 1'b0;
                if (k == halt_cyc) begin
                    cpu_wrEn = 1'b1; cpu_addr = 10'd1023; cpu_wdata = code;
                end else begin
                    cpu_wrEn = 1'($urandom_range(0, 1)); cpu_addr = 10'($urandom_range(16, 31)); cpu_wdata = $urandom;
                end
                @(negedge clk);
                checks++; if (busy !== 1'b1 || cycles !== 32'(k - 1) || cpu_rdata !== exp_rd || ram_we !== cpu_wrEn || ram_wdata !== cpu_wdata) begin failures++; $display("FAIL rand%0d_cyc%0d busy=%0b cycles=%0d rd=%h exp_rd=%h we=%0b", r, k, busy, cycles, cpu_rdata, exp_rd, ram_we); end
                exp_rd = exp_mem[cpu_addr];
                if (cpu_wrEn) exp_mem[cpu_addr] = cpu_wdata;
            end
            @(posedge clk); #1;
            cpu_wrEn = 1'b0;
            @(negedge clk);
            checks++; if (done !== 1'b1 || timeout !== exp_to || cycles !== 32'(exp_end) || halt_code !== exp_code || cpu_rst !== 1'b1) begin failures++; $display("FAIL rand%0d_end done=%0b to=%0b cycles=%0d code=%h exp=1/%0b/%0d/%h", r, done, timeout, cycles, halt_code, exp_to, exp_end, exp_code); end
            // Random host traffic in DONE checked against the expected memory image.
            exp_v = 1'b0; exp_d = 32'd0;
            for (int j = 0; j <= 8; j++) begin
                @(posedge clk); #1;
                host_req = (j < 8) ? 1'($urandom_range(0, 1)) : 1'b0;
                host_we = 1'($urandom_range(0, 1)); host_addr = 10'($urandom_range(0, 31)); host_wdata = $urandom;
                @(negedge clk);
                checks++; if (host_rvalid !== exp_v || host_rdata !== (exp_v ? exp_d : 32'd0) || host_gnt !== host_req) begin failures++; $display("FAIL rand%0d_host%0d rv=%0b rd=%h gnt=%0b exp=%0b/%h/%0b", r, j, host_rvalid, host_rdata, host_gnt, exp_v, exp_v ? exp_d : 32'd0, host_req); end
                exp_v = host_req && !host_we;
                exp_d = exp_mem[host_addr];
                if (host_req && host_we) exp_mem[host_addr] = host_wdata;
            end
        end
    endtask

    task automatic test_reset_midrun();
        logic [31:0] old20;
        old20 = exp_mem[20];
        @(posedge clk); #1;
        start = 1'b1; host_req = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            cpu_wrEn = (k == 10); cpu_addr = (k == 10) ? 10'd20 : 10'd3; cpu_wdata = 32'hBADC0DE;
        end
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        checks++; if (cpu_rst !== 1'b1 || busy !== 1'b0 || ram_we !== 1'b0 || cycles !== 32'd0) begin failures++; $display("FAIL midrun_async cpu_rst=%0b busy=%0b we=%0b cycles=%0d exp=1/0/0/0", cpu_rst, busy, ram_we, cycles); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1; cpu_wrEn = 1'b0;
        host_req = 1'b1; host_we = 1'b0; host_addr = 10'd20;
        @(posedge clk); #1;
        host_req = 1'b0;
        @(negedge clk);
        checks++; if (host_rvalid !== 1'b1 || host_rdata !== old20) begin failures++; $display("FAIL midrun_no_write got=%0b/%h exp=1/%h", host_rvalid, host_rdata, old20); end
    endtask

`ifdef RUN_ABORT_EN
    task automatic test_abort();
        @(posedge clk); #1;
        start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            start = 1'b0; abort = (k == 10);
        end
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        checks++; if (done !== 1'b1 || halt_code !== 32'hFFFF_FFFF || timeout !== 1'b0 || cycles !== 32'd10) begin failures++; $display("FAIL abort_end done=%0b code=%h to=%0b cycles=%0d exp=1/ffffffff/0/10", done, halt_code, timeout, cycles); end
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        checks++; if (done !== 1'b1 || cycles !== 32'd10) begin failures++; $display("FAIL abort_ignored done=%0b cycles=%0d exp=1/10", done, cycles); end
    endtask
`endif

    initial begin
        test_reset();
        test_host_load();
        test_halt_run();
        test_timeout();
        test_host_blocked();
        test_random_runs();
        test_reset_midrun();
`ifdef RUN_ABORT_EN
        test_abort();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
